uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmit serializer, directly downstream of baud_tick_gen.
//  - Consumes its one-clock baud_tick pulse as the bit-period strobe.
//  - Accepts a parallel byte over a valid/ready handshake.
//  - Shifts out one frame: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop.
//  - Single clock domain shared with baud_tick_gen.
// PARAMETERS
//  DATA_BITS   8  data bits per frame, legal 5..8
//  STOP_BITS   1  stop bits per frame, legal 1..2
//  PARITY_ODD  0  0 = even parity, 1 = odd; used only with UART_TX_PARITY_EN
// PORTS
//  clock      in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-low reset
//  baud_tick  in   1          1-cycle strobe from baud_tick_gen, one per bit period
//  tx_data    in   DATA_BITS  byte to send; sampled only on the accept cycle
//  tx_valid   in   1          byte available
//  tx_ready   out  1          block idle and able to accept
//  tx         out  1          serial line, registered, idle high
//  tx_busy    out  1          high from accept until the frame completes
//  tx_done    out  1          1-cycle pulse on the cycle after the last stop bit ends
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//    state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0,
//    shift register=0, bit counter=0.
//  Handshake: accept when tx_valid & tx_ready at a rising edge.
//    On accept: latch tx_data into shift reg; tx_ready=0, tx_busy=1 the next cycle.
//  FSM: IDLE -> SYNC -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  Advances happen only on cycles with baud_tick=1, except IDLE->SYNC on accept.
//  SYNC:   tx=1; wait for the first baud_tick after accept.
//          A tick in the accept cycle itself is ignored.
//          On a tick -> START, tx=0.
//  START:  on tick -> DATA; tx=shift[0]; counter=0.
//  DATA:   on tick: shift right, counter+1, tx=next bit.
//          After DATA_BITS bits -> PARITY, or -> STOP if parity is disabled.
//  PARITY: tx = ^data (even) or ~^data (odd), computed from the latched byte.
//          On tick -> STOP, tx=1.
//  STOP:   tx=1 for STOP_BITS tick intervals.
//          On the final tick -> IDLE, tx_ready=1, tx_busy=0, tx_done=1 for one cycle.
//  Bit timing:
//    - Every bit lasts exactly one baud_tick interval.
//    - tx changes only on the clock after a baud_tick.
//  Latency: accept to start-bit edge = 1 cycle after the first tick following accept.
//  Boundary conditions:
//    - tx_valid while busy: ignored, no latch; tx_data changes mid-frame have no effect.
//    - tx_valid held high at frame end: the next accept occurs in the first IDLE cycle.
//      A back-to-back frame goes through SYNC; there is no bit-period gap beyond SYNC.
//    - Reset asserted mid-frame: tx=1 immediately (async), frame aborted, no tx_done.
//    - baud_tick absent: the FSM holds its state indefinitely.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    - PARITY state present; frame = 1 + DATA_BITS + 1 + STOP_BITS bits.
//    - PARITY_ODD selects the sense.
//  UART_TX_PARITY_EN undefined:
//    - No PARITY state, no parity logic; DATA goes directly to STOP.
//    - PARITY_ODD is ignored.
// TESTING
//  1. Reset low 20ns, then release -> tx=1, tx_ready=1, tx_busy=0, tx_done=0.
//  2. tick every 4 clk, send 0x55 (no parity) -> tx = 0,1,0,1,0,1,0,1,0,1,
//     each bit 4 clk, tx_done pulses once, tx_ready back to 1.
//  3. UART_TX_PARITY_EN, PARITY_ODD=0, send 0xA5 -> data 1,0,1,0,0,1,0,1,
//     parity 0, stop 1; PARITY_ODD=1 -> parity 1.
//  4. tx_valid held, bytes 0x01 then 0x80 -> two full frames, tx_done twice,
//     second byte latched only after the first tx_done.
//  5. reset pulsed low during data bit 3 -> tx=1 same cycle, no tx_done,
//     a fresh 0x3C frame afterwards is correct.
//  6. baud_tick in the same cycle as accept -> ignored; the start bit begins
//     only after the next tick, with full width.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DATA_BITS data LSB-first, optional parity, STOP_BITS stop.
// Define UART_TX_PARITY_EN to insert the parity bit; PARITY_ODD then selects odd (1) or even (0).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
`endif

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;

`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`else
  // PARITY_ODD has no effect when the frame carries no parity bit.
  logic                 unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        // A tick coinciding with the accept is ignored: SYNC waits for the next one.
        if (tx_valid && tx_ready_q) begin
          state_d    = SYNC;
          shift_d    = tx_data;
          cnt_d      = 3'd0;
          tx_d       = 1'b1;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      SYNC: begin
        if (baud_tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          cnt_d   = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_q == LAST_DATA) begin
            cnt_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = 3'd0;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (cnt_q == LAST_STOP) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            tx_ready_d = 1'b1;
            tx_busy_d  = 1'b0;
            tx_done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= 3'd0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: baud tick every 4 clocks, frames checked bit by bit on falling edges.
// With UART_TX_PARITY_EN a second, odd-parity instance runs in lockstep with the even one.
module tb_uart_tx;
  localparam int DATA_BITS = 8;
  localparam int TICK_DIV  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clock;
  logic       reset;
  logic       baud_tick;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic       tick_en;
  int         total;
  int         bad;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

`ifdef UART_TX_PARITY_EN
  logic odd_ready, odd_tx, odd_busy, odd_done;
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b1)) dut_odd (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(odd_ready), .tx(odd_tx), .tx_busy(odd_busy), .tx_done(odd_done)
  );
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Tick generator: baud_tick is set just after a rising edge so the next edge sees it.
  initial begin
    int phase;
    phase     = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      phase     = (phase + 1) % TICK_DIV;
      baud_tick = tick_en && (phase == 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits on a falling edge; returns on the falling edge after the accept.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    bit accepted;
    accepted = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 64 && !accepted; k++) begin
      if (tx_ready) accepted = 1'b1;
      @(negedge clock);
    end
    check_output("accept", accepted, 1'b1);
    if (!hold) tx_valid = 1'b0;
    check_output("accept_busy", tx_busy, 1'b1);
    check_output("accept_ready", tx_ready, 1'b0);
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check_output("start_seen", seen, 1'b1);
  endtask

  // Starts on the first falling edge of the start bit; p is the hand-computed even parity.
  task automatic check_frame(input logic [7:0] b, input logic p);
    logic exp_bit;
    $display("[TB] frame %02h parity %0b", b, p);
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i == 0) exp_bit = 1'b0;
      else if (i <= DATA_BITS) exp_bit = b[i-1];
`ifdef UART_TX_PARITY_EN
      else if (i == DATA_BITS + 1) exp_bit = p;
`endif
      else exp_bit = 1'b1;
      for (int c = 0; c < TICK_DIV; c++) begin
        check_output($sformatf("f%02h_bit%0d_c%0d", b, i, c), tx, exp_bit);
`ifdef UART_TX_PARITY_EN
        check_output($sformatf("odd_f%02h_bit%0d_c%0d", b, i, c), odd_tx,
                     (i == DATA_BITS + 1) ? ~p : exp_bit);
`endif
        if (c == 0) begin
          check_output($sformatf("f%02h_busy%0d", b, i), tx_busy, 1'b1);
          check_output($sformatf("f%02h_nodone%0d", b, i), tx_done, 1'b0);
        end
        @(negedge clock);
      end
    end
    check_output("end_done", tx_done, 1'b1);
    check_output("end_ready", tx_ready, 1'b1);
    check_output("end_busy", tx_busy, 1'b0);
    check_output("end_tx", tx, 1'b1);
`ifdef UART_TX_PARITY_EN
    check_output("odd_end_done", odd_done, 1'b1);
`endif
    @(negedge clock);
    check_output("done_one_cycle", tx_done, 1'b0);
  endtask

  initial begin
    bit aligned;
    bit saw_done;
    bit saw_low;
    bit done_seen;
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick_en  = 1'b1;

    // Reset held low for 20 ns
    repeat (2) @(negedge clock);
    check_output("rst_tx", tx, 1'b1);
    check_output("rst_ready", tx_ready, 1'b1);
    check_output("rst_busy", tx_busy, 1'b0);
    check_output("rst_done", tx_done, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check_output("idle_tx", tx, 1'b1);
    check_output("idle_ready", tx_ready, 1'b1);
    check_output("idle_busy", tx_busy, 1'b0);
    check_output("idle_done", tx_done, 1'b0);

    $display("[TB] basic frame 0x55");
    send_byte(8'h55, 1'b0);
    wait_start();
    check_frame(8'h55, 1'b0);

    $display("[TB] frame 0xA5");
    send_byte(8'hA5, 1'b0);
    wait_start();
    check_frame(8'hA5, 1'b0);

    $display("[TB] back-to-back with tx_valid held");
    send_byte(8'h01, 1'b1);
    tx_data = 8'h80;
    wait_start();
    check_frame(8'h01, 1'b1);
    check_output("b2b_busy", tx_busy, 1'b1);
    check_output("b2b_ready", tx_ready, 1'b0);
    tx_valid = 1'b0;
    wait_start();
    check_frame(8'h80, 1'b1);
    repeat (8) @(negedge clock);
    check_output("b2b_idle_ready", tx_ready, 1'b1);
    check_output("b2b_idle_tx", tx, 1'b1);

    $display("[TB] reset during data bit 3");
    send_byte(8'h00, 1'b0);
    wait_start();
    repeat (4 * TICK_DIV + 1) @(negedge clock);
    check_output("abort_pre_tx", tx, 1'b0);
    reset = 1'b0;
    #1;
    check_output("abort_tx", tx, 1'b1);
    check_output("abort_busy", tx_busy, 1'b0);
    check_output("abort_ready", tx_ready, 1'b1);
    check_output("abort_done", tx_done, 1'b0);
    @(negedge clock);
    reset    = 1'b1;
    saw_done = 1'b0;
    saw_low  = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clock);
      if (tx_done !== 1'b0) saw_done = 1'b1;
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check_output("abort_no_done", saw_done, 1'b0);
    check_output("abort_line_idle", saw_low, 1'b0);
    send_byte(8'h3C, 1'b0);
    wait_start();
    check_frame(8'h3C, 1'b0);

    $display("[TB] tick in the accept cycle");
    aligned = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (baud_tick) begin
        aligned = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check_output("tick_aligned", aligned, 1'b1);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    check_output("sync_busy", tx_busy, 1'b1);
    for (int k = 0; k < TICK_DIV; k++) begin
      check_output($sformatf("sync_hold%0d", k), tx, 1'b1);
      @(negedge clock);
    end
    check_output("sync_start", tx, 1'b0);
    check_frame(8'h96, 1'b0);

    $display("[TB] baud_tick absent holds state");
    send_byte(8'h55, 1'b0);
    wait_start();
    tick_en = 1'b0;
    repeat (20) @(negedge clock);
    check_output("hold_tx", tx, 1'b0);
    check_output("hold_busy", tx_busy, 1'b1);
    check_output("hold_done", tx_done, 1'b0);
    tick_en   = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 100 && !done_seen; k++) begin
      @(negedge clock);
      if (tx_done === 1'b1) done_seen = 1'b1;
    end
    check_output("resume_done", done_seen, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
